// File: rtl/dma_responder_if.sv
// Bundled accelerator DMA handshake, Wishbone master bus and error-reporting signals for dma_responder.
// The slave modport is the responder's view; the master modport is the accelerator/memory side.
interface dma_responder_if;
    logic        acc_req_i;
    logic        acc_we_i;
    logic [31:0] acc_addr_i;
    logic [31:0] acc_wdata_i;
    logic        acc_ack_o;
    logic [31:0] acc_rdata_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        err_o;
    logic        err_clr_i;
    logic [31:0] err_addr_o;

    modport slave (
        input  acc_req_i, acc_we_i, acc_addr_i, acc_wdata_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i, err_clr_i,
        output acc_ack_o, acc_rdata_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output err_o, err_addr_o
    );

    modport master (
        output acc_req_i, acc_we_i, acc_addr_i, acc_wdata_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i, err_clr_i,
        input  acc_ack_o, acc_rdata_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  err_o, err_addr_o
    );
endinterface

// File: rtl/dma_responder.sv
// Turns each accelerator DMA request into one single-beat Wishbone cycle and returns a one-cycle ack.
// Optional address-window check enabled by defining DMA_RESP_WINDOW_EN.
module dma_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter logic [31:0] WIN_BASE       = 32'h0000_0000,
    parameter logic [31:0] WIN_SIZE       = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    dma_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES);

`ifdef DMA_RESP_WINDOW_EN
    localparam bit WIN_CHECK = 1'b1;
`else
    localparam bit WIN_CHECK = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        in_bus;
    logic        win_out;
    logic        req_bad;
    logic        err_set;
    logic        bus_fail;
    logic [15:0] tmo_inc;

    // 33-bit compare so WIN_BASE + WIN_SIZE cannot wrap past 2^32.
    assign win_out = ({1'b0, bus.acc_addr_i} <  {1'b0, WIN_BASE}) ||
                     ({1'b0, bus.acc_addr_i} >= ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
    assign req_bad = (bus.acc_addr_i[1:0] != 2'b00) || (WIN_CHECK && win_out);
    assign tmo_inc = tmo_q + 16'd1;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        err_addr_d = err_addr_q;
        err_set    = 1'b0;
        bus_fail   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.acc_req_i) begin
                    addr_d  = bus.acc_addr_i;
                    we_d    = bus.acc_we_i;
                    wdata_d = bus.acc_wdata_i;
                    tmo_d   = 16'd0;
                    if (req_bad) begin
                        err_set    = 1'b1;
                        err_addr_d = bus.acc_addr_i;
                        if (!bus.acc_we_i) rdata_d = ERR_DATA;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (bus.wbm_err_i) begin
                    bus_fail = 1'b1;
                end else if (bus.wbm_ack_i) begin
                    if (!we_q) rdata_d = bus.wbm_dat_i;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LAST) bus_fail = 1'b1;
                end
                if (bus_fail) begin
                    err_set    = 1'b1;
                    err_addr_d = addr_q;
                    if (!we_q) rdata_d = ERR_DATA;
                    state_d    = S_RESP;
                end
            end
            S_RESP:  state_d = S_GAP;
            default: state_d = S_IDLE;
        endcase

        // A new error outranks a simultaneous clear.
        err_d = err_set | (err_q & ~bus.err_clr_i);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign in_bus          = (state_q == S_BUS);
    assign bus.wbm_cyc_o   = in_bus;
    assign bus.wbm_stb_o   = in_bus;
    assign bus.wbm_we_o    = in_bus & we_q;
    assign bus.wbm_sel_o   = {4{in_bus}};
    assign bus.wbm_adr_o   = addr_q;
    assign bus.wbm_dat_o   = wdata_q;
    assign bus.acc_ack_o   = (state_q == S_RESP);
    assign bus.acc_rdata_o = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_dma_responder.sv
// Self-checking bench for dma_responder: directed table, reset/back-to-back sequences, random vs model.
// Runs with TIMEOUT_CYCLES = 8; the window case is exercised only when DMA_RESP_WINDOW_EN is defined.
module tb_dma_responder;

    localparam int          T      = 8;
    localparam logic [31:0] ERR    = 32'hDEADBEEF;
    localparam int          K_ACK  = 0;
    localparam int          K_ERR  = 1;
    localparam int          K_NONE = 2;
    localparam int          K_BOTH = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dma_responder_if bus ();

    dma_responder #(.TIMEOUT_CYCLES(T)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          kind;
        logic [31:0] rd;
        logic        clr;
        int          exp_bus;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t tbl [12];

    // reference model state: what the responder should be reporting
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_eaddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.acc_req_i   = 1'b0;
        bus.acc_we_i    = 1'b0;
        bus.acc_addr_i  = '0;
        bus.acc_wdata_i = '0;
        bus.wbm_dat_i   = '0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        bus.err_clr_i   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction; the memory answers after `waits` wait states with response `kind`.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input int kind, input logic [31:0] rd, input logic clr,
                           output int bus_n, output int lat, output logic [31:0] rdata,
                           output logic errv, output logic [31:0] eaddr);
        bus_n = 0; lat = -1; rdata = '0; errv = 1'b0; eaddr = '0;
        @(negedge clk);
        bus.acc_req_i   = 1'b1;
        bus.acc_we_i    = we;
        bus.acc_addr_i  = addr;
        bus.acc_wdata_i = wdata;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        bus.err_clr_i   = clr;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = ~rd;
            if (bus.wbm_cyc_o) begin
                bus_n++;
                check("wbm_adr", bus.wbm_adr_o, addr);
                check("wbm_we", 32'(bus.wbm_we_o), 32'(we));
                check("wbm_stb", 32'(bus.wbm_stb_o), 32'(bus.wbm_cyc_o));
                check("wbm_sel", 32'(bus.wbm_sel_o), 32'h0000_000F);
                if (we) check("wbm_dat", bus.wbm_dat_o, wdata);
                if (bus_n == waits + 1) begin
                    case (kind)
                        K_ACK:  begin bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = rd; end
                        K_ERR:  bus.wbm_err_i = 1'b1;
                        K_BOTH: begin bus.wbm_ack_i = 1'b1; bus.wbm_err_i = 1'b1; bus.wbm_dat_i = rd; end
                        default: ;
                    endcase
                end
            end
            if (bus.acc_ack_o) begin
                lat   = c;
                rdata = bus.acc_rdata_o;
                errv  = bus.err_o;
                eaddr = bus.err_addr_o;
                break;
            end
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_wait: no acc_ack_o within 40 cycles for addr %h", addr);
        end
        // drop the request and poke unsolicited responses: no second ack, no bus cycle
        bus.acc_req_i = 1'b0;
        bus.err_clr_i = 1'b0;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_err_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("single_ack", 32'(bus.acc_ack_o), 32'h0);
            check("no_extra_cyc", 32'(bus.wbm_cyc_o), 32'h0);
        end
        check("err_hold", 32'(bus.err_o), 32'(errv));
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
    endtask

    // Transaction-level prediction: bus length, ack latency and reported state.
    task automatic model(input logic we, input logic [31:0] addr, input int waits, input int kind,
                         input logic [31:0] rd, input logic clr, output int exp_bus, output int exp_lat);
        logic fail;
        logic bad_addr;
        bad_addr = (addr % 4) != 0;
`ifdef DMA_RESP_WINDOW_EN
        bad_addr = bad_addr || (addr >= 32'h0001_0000);
`endif
        if (bad_addr) begin
            exp_bus = 0;
            fail    = 1'b1;
        end else if (kind == K_NONE || waits + 1 > T) begin
            exp_bus = T;
            fail    = 1'b1;
        end else begin
            exp_bus = waits + 1;
            fail    = (kind == K_ERR) || (kind == K_BOTH);
        end
        exp_lat = exp_bus + 1;
        if (!we) m_rdata = fail ? ERR : rd;
        if (fail) begin
            m_err   = 1'b1;
            m_eaddr = addr;
        end else if (clr) begin
            m_err = 1'b0;
        end
    endtask

    initial begin
        int          bus_n, lat, eb, el;
        logic [31:0] rdata, eaddr;
        logic        errv;

        //             we    addr           wdata          w  kind    rd             clr  bus lat rdata          err  eaddr
        tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0,         0, K_ACK,  32'h1234_5678, 1'b0, 1, 2, 32'h1234_5678, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 3, K_ACK,  32'h0,         1'b0, 4, 5, 32'h1234_5678, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0300, 32'h0,         0, K_NONE, 32'h0,         1'b0, 8, 9, ERR,           1'b1, 32'h300};
        tbl[3]  = '{1'b0, 32'h0000_0104, 32'h0,         2, K_ACK,  32'h0BAD_F00D, 1'b1, 3, 4, 32'h0BAD_F00D, 1'b0, 32'h300};
        tbl[4]  = '{1'b0, 32'h0000_0102, 32'h0,         0, K_ACK,  32'h0,         1'b0, 0, 1, ERR,           1'b1, 32'h102};
        tbl[5]  = '{1'b0, 32'h0000_0108, 32'h0,         0, K_ACK,  32'h1111_2222, 1'b1, 1, 2, 32'h1111_2222, 1'b0, 32'h102};
        tbl[6]  = '{1'b1, 32'h0000_0203, 32'h5555_AAAA, 0, K_ACK,  32'h0,         1'b1, 0, 1, 32'h1111_2222, 1'b1, 32'h203};
        tbl[7]  = '{1'b0, 32'h0000_010C, 32'h0,         1, K_BOTH, 32'h3333_4444, 1'b1, 2, 3, ERR,           1'b1, 32'h10C};
        tbl[8]  = '{1'b1, 32'h0000_0110, 32'h7777_8888, 0, K_ERR,  32'h0,         1'b0, 1, 2, ERR,           1'b1, 32'h110};
        tbl[9]  = '{1'b0, 32'h0000_0114, 32'h0,         7, K_ACK,  32'hA5A5_5A5A, 1'b1, 8, 9, 32'hA5A5_5A5A, 1'b0, 32'h110};
        tbl[10] = '{1'b0, 32'h0000_0118, 32'h0,         8, K_ACK,  32'h9999_0000, 1'b0, 8, 9, ERR,           1'b1, 32'h118};
        tbl[11] = '{1'b1, 32'h0000_011C, 32'h1357_2468, 0, K_ACK,  32'h0,         1'b0, 1, 2, ERR,           1'b1, 32'h118};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.acc_ack_o), 32'h0);
        check("rst_rdata", bus.acc_rdata_o, 32'h0);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'h0);
        check("rst_we", 32'(bus.wbm_we_o), 32'h0);
        check("rst_adr", bus.wbm_adr_o, 32'h0);
        check("rst_dat", bus.wbm_dat_o, 32'h0);
        check("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
        check("rst_err", 32'(bus.err_o), 32'h0);
        check("rst_eaddr", bus.err_addr_o, 32'h0);
        reset = 1'b0;

        // reset in the middle of a bus cycle, with an ack arriving on the reset edge
        @(negedge clk);
        bus.acc_req_i  = 1'b1;
        bus.acc_addr_i = 32'h0000_0400;
        repeat (2) begin
            @(negedge clk);
            check("mid_cyc", 32'(bus.wbm_cyc_o), 32'h1);
        end
        reset         = 1'b1;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h4444_4444;
        @(posedge clk);
        #1;
        check("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
        check("mid_rst_stb", 32'(bus.wbm_stb_o), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_noack", 32'(bus.acc_ack_o), 32'h0);
            check("mid_rst_nocyc", 32'(bus.wbm_cyc_o), 32'h0);
        end
        check("mid_rst_rdata", bus.acc_rdata_o, 32'h0);

        for (int i = 0; i < 12; i++) begin
            do_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].kind, tbl[i].rd,
                    tbl[i].clr, bus_n, lat, rdata, errv, eaddr);
            check($sformatf("t%0d_bus", i), 32'(bus_n), 32'(tbl[i].exp_bus));
            check($sformatf("t%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("t%0d_rdata", i), rdata, tbl[i].exp_rdata);
            check($sformatf("t%0d_err", i), 32'(errv), 32'(tbl[i].exp_err));
            check($sformatf("t%0d_eaddr", i), eaddr, tbl[i].exp_eaddr);
        end

`ifdef DMA_RESP_WINDOW_EN
        do_xfer(1'b0, 32'h0002_0000, 32'h0, 0, K_ACK, 32'h0, 1'b0, bus_n, lat, rdata, errv, eaddr);
        check("win_bus", 32'(bus_n), 32'h0);
        check("win_lat", 32'(lat), 32'h1);
        check("win_rdata", rdata, ERR);
        check("win_err", 32'(errv), 32'h1);
        check("win_eaddr", eaddr, 32'h0002_0000);
`endif

        // 64 back-to-back zero-wait reads, address advanced on each ack
        do_reset();
        begin
            logic [31:0] cur;
            int          prev, acks, busc;
            cur  = 32'h0000_1000;
            prev = -1;
            acks = 0;
            busc = 0;
            bus.acc_req_i  = 1'b1;
            bus.acc_addr_i = cur;
            for (int c = 0; c < 64 * 4 + 20 && acks < 64; c++) begin
                @(negedge clk);
                bus.wbm_ack_i = 1'b0;
                if (bus.wbm_cyc_o) begin
                    busc++;
                    check("b2b_adr", bus.wbm_adr_o, cur);
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_dat_i = cur ^ 32'h5A5A_0000;
                end
                if (bus.acc_ack_o) begin
                    check("b2b_rdata", bus.acc_rdata_o, cur ^ 32'h5A5A_0000);
                    if (prev >= 0) check("b2b_spacing", 32'(c - prev), 32'd4);
                    prev = c;
                    acks++;
                    cur += 32'd4;
                    bus.acc_addr_i = cur;
                    if (acks == 64) bus.acc_req_i = 1'b0;
                end
            end
            idle_inputs();
            check("b2b_acks", 32'(acks), 32'd64);
            check("b2b_buscycles", 32'(busc), 32'd64);
        end

        // randomized transactions against the transaction-level model
        do_reset();
        m_rdata = '0;
        m_err   = 1'b0;
        m_eaddr = '0;
        for (int i = 0; i < 40; i++) begin
            logic        we, clr;
            logic [31:0] addr, wdata, rd;
            int          waits, kind;
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 4) == 0) addr = addr | 32'($urandom_range(1, 3));
            wdata = $urandom;
            rd    = $urandom;
            waits = $urandom_range(0, 9);
            kind  = $urandom_range(0, 3);
            clr   = ($urandom_range(0, 5) == 0);
            model(we, addr, waits, kind, rd, clr, eb, el);
            do_xfer(we, addr, wdata, waits, kind, rd, clr, bus_n, lat, rdata, errv, eaddr);
            check($sformatf("r%0d_bus", i), 32'(bus_n), 32'(eb));
            check($sformatf("r%0d_lat", i), 32'(lat), 32'(el));
            check($sformatf("r%0d_rdata", i), rdata, m_rdata);
            check($sformatf("r%0d_err", i), 32'(errv), 32'(m_err));
            check($sformatf("r%0d_eaddr", i), eaddr, m_eaddr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_responder.md
Name: dma_responder

Overview:
- Memory-side end of the accelerator DMA port; services the matrix accelerator's DMA initiator requests.
- Each accepted request is translated into one single-beat Wishbone master cycle to system memory.
- On completion it returns a one-cycle acknowledge, plus read data for read requests.
- Sits between the matrix accelerator's DMA port and the SoC bus interconnect.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for wbm_ack_i/wbm_err_i before aborting; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF: value returned on acc_rdata_o for any failed read.
- WIN_BASE, 32'h0000_0000: legal window base address; used only with DMA_RESP_WINDOW_EN.
- WIN_SIZE, 32'h0001_0000: legal window size in bytes; used only with DMA_RESP_WINDOW_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- acc_req_i  input  1  accelerator request, level; held until acc_ack_o
- acc_we_i  input  1  1 = write, 0 = read
- acc_addr_i  input  32  byte address
- acc_wdata_i  input  32  write data from accelerator
- acc_ack_o  output  1  one-cycle completion pulse
- acc_rdata_o  output  32  read data, valid in the acc_ack_o cycle
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_adr_o  output  32  Wishbone address
- wbm_dat_o  output  32  Wishbone write data
- wbm_sel_o  output  4  byte selects; always 4'hF during a cycle
- wbm_dat_i  input  32  Wishbone read data
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_err_i  input  1  Wishbone error
- err_o  output  1  sticky error flag
- err_clr_i  input  1  clears err_o
- err_addr_o  output  32  address of the most recent failed request

Behaviour:
- Interface decided: one clock, clk; reset named reset, synchronous and active-high.
- Reset values:
  - all outputs 0, except acc_rdata_o = 0 and wbm_sel_o = 0.
  - FSM enters IDLE; timeout counter 0.
- FSM states: IDLE, BUS, RESP, GAP.
- IDLE:
  - On acc_req_i = 1, register addr/we/wdata.
  - If addr[1:0] != 0, go to RESP as an error; no bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; wbm_sel_o = 4'hF; adr/dat/we driven from the registered values.
  - Registered values stay stable for the whole cycle, regardless of acc_* changes.
  - wbm_err_i = 1: error, go to RESP. Error wins if wbm_ack_i is asserted in the same cycle.
  - Else wbm_ack_i = 1: success; capture wbm_dat_i on reads; go to RESP.
  - Else increment the timeout counter; when it reaches TIMEOUT_CYCLES with no ack, error, go to RESP.
  - cyc/stb deassert on the edge that leaves BUS.
- RESP:
  - acc_ack_o = 1 for exactly this cycle.
  - acc_rdata_o holds captured data on a successful read, ERR_DATA on a failed read, and its previous value on writes.
  - Next state is GAP.
- GAP:
  - One turnaround cycle in which acc_req_i is ignored, so the accelerator can advance its address.
  - Next state is IDLE.
- Latency with zero-wait-state memory (wbm_ack_i in the first BUS cycle):
  - req seen in cycle 0 -> BUS in cycle 1 -> acc_ack_o in cycle 2.
  - Back-to-back throughput: one transfer per 4 cycles.
- Error handling:
  - Any error sets err_o and loads err_addr_o.
  - err_o stays set until err_clr_i = 1.
  - If a new error and err_clr_i occur in the same cycle, set wins.
  - Errors still complete the handshake (acc_ack_o pulses); the accelerator never hangs.
- Unsolicited wbm_ack_i/wbm_err_i outside BUS are ignored.
- acc_req_i dropping while in BUS does not abort the transfer; the ack is still issued.
- Reset mid-transfer: on the reset edge cyc/stb drop and any pending ack is discarded.

Optional Feature:
- Macro: DMA_RESP_WINDOW_EN.
- Defined:
  - In IDLE, an address outside [WIN_BASE, WIN_BASE+WIN_SIZE) is an error.
  - No bus cycle is issued; err_o is set and err_addr_o loaded; go straight to RESP.
  - acc_rdata_o = ERR_DATA for reads.
  - The compare uses 33-bit arithmetic so base+size does not wrap.
- Undefined: no window check; all aligned addresses go to the bus.

Test Plan:
- Read, memory acks in the first BUS cycle with wbm_dat_i = 32'h1234_5678 at addr 32'h100 -> wbm_adr_o = 32'h100, wbm_we_o = 0; acc_ack_o pulses 2 cycles after req with acc_rdata_o = 32'h1234_5678; err_o = 0.
- Write of 32'hCAFE_F00D to 32'h200 with 3 wait states -> wbm_dat_o = 32'hCAFEF00D, wbm_sel_o = 4'hF, cyc held 4 cycles; a single acc_ack_o pulse.
- 64 back-to-back reads with req held and addr advanced on each ack -> 64 acks, each at a 4-cycle spacing; no duplicated bus cycles.
- Read with TIMEOUT_CYCLES = 8 and no memory ack -> cyc drops after 8 cycles; acc_ack_o pulses with rdata 32'hDEADBEEF; err_o = 1 and err_addr_o = addr. A later err_clr_i clears err_o.
- Misaligned read at 32'h102 -> no wbm_cyc_o; acc_ack_o pulses with ERR_DATA; err_o = 1. With DMA_RESP_WINDOW_EN, a read at 32'h0002_0000 behaves identically.
- Reset asserted during BUS, then wbm_ack_i and wbm_err_i asserted together in a later transfer -> on reset, cyc/stb = 0 the next cycle and no ack is issued. On the later transfer, err wins: err_o = 1 and rdata = ERR_DATA.
